// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: instruction-fetch / next-PC stage ahead of control_unit.
//   Holds the PC and fetches one word at a time over a req/ready handshake.
//   It then waits one cycle for control_unit's registered decode.
//   Finally it resolves the next PC from the 4-bit branch select.
// Optional feature macro: MISALIGN_TRAP_EN. When it is defined, a jr to a
//   misaligned target redirects to TRAP_PC and pulses misalign.
// Ports:
//   clk, rst           clock / synchronous active-high reset
//   imem_req/addr      fetch request and address (= pc)
//   imem_ready/rdata   memory accept + returned word (same cycle)
//   ir_out/ir_valid    latched instruction for decode, valid flag
//   pc_out             PC of the instruction held in ir_out
//   branch             branch select from control_unit
//   rs_val/rt_val      register operands (signed compares)
//   stall              holds RESOLVE
//   taken              1-cycle pulse when the PC leaves the pc+4 path
//   link_addr          pc+4 captured on jal
//   misalign           1-cycle pulse on a trapped misaligned jr
module pc_fetch_unit #(
  parameter int unsigned          ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]    RESET_PC = '0,
  parameter logic [ADDR_W-1:0]    TRAP_PC  = ADDR_W'(32'h0000_0080)
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       ir_out,
  output logic              ir_valid,
  output logic [ADDR_W-1:0] pc_out,
  input  logic [3:0]        branch,
  input  logic [31:0]       rs_val,
  input  logic [31:0]       rt_val,
  input  logic              stall,
  output logic              taken,
  output logic [ADDR_W-1:0] link_addr,
  output logic              misalign
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FETCH    = 2'd1,
    WAIT_CTL = 2'd2,
    RESOLVE  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic              idle_wait_q;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] p4, bt, jt, npc;
  logic              cond, trap;

  assign imem_addr = pc_q;

  // State sequencing and request decode.
  // IDLE holds for one full cycle after reset release.
  always_comb begin
    state_d  = state_q;
    imem_req = 1'b0;
    case (state_q)
      IDLE:     if (!idle_wait_q) state_d = FETCH;
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) state_d = WAIT_CTL;
      end
      WAIT_CTL: state_d = RESOLVE;
      RESOLVE:  if (!stall) state_d = FETCH;
      default:  state_d = IDLE;
    endcase
  end

  // Next-PC resolution.
  always_comb begin
    p4   = pc_q + ADDR_W'(4);
    bt   = p4 + {{(ADDR_W-18){ir_out[15]}}, ir_out[15:0], 2'b00};
    jt   = {p4[ADDR_W-1:28], ir_out[25:0], 2'b00};
    cond = 1'b0;
    trap = 1'b0;
    case (branch)
      4'b0011: cond = (rs_val == rt_val);
      4'b0100: cond = (rs_val != rt_val);
      4'b0101: cond = ($signed(rs_val) <= 0);
      4'b0110: cond = ($signed(rs_val) > 0);
      4'b0111: cond = ($signed(rs_val) <  $signed(rt_val));
      4'b1000: cond = ($signed(rs_val) >  $signed(rt_val));
      4'b1001: cond = ($signed(rs_val) >= $signed(rt_val));
      4'b1010: cond = ($signed(rs_val) <= $signed(rt_val));
      default: cond = 1'b0;
    endcase
    case (branch)
      4'b0001, 4'b1011: npc = jt;
`ifdef MISALIGN_TRAP_EN
      4'b0010: begin
        trap = (rs_val[1:0] != 2'b00);
        npc  = trap ? TRAP_PC : {rs_val[ADDR_W-1:2], 2'b00};
      end
`else
      4'b0010: npc = {rs_val[ADDR_W-1:2], 2'b00};
`endif
      4'b0011, 4'b0100, 4'b0101, 4'b0110,
      4'b0111, 4'b1000, 4'b1001, 4'b1010: npc = cond ? bt : p4;
      default: npc = p4;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idle_wait_q <= 1'b1;
      pc_q        <= RESET_PC;
      ir_out      <= '0;
      ir_valid    <= 1'b0;
      pc_out      <= '0;
      taken       <= 1'b0;
      link_addr   <= '0;
      misalign    <= 1'b0;
    end else begin
      state_q  <= state_d;
      taken    <= 1'b0;
      misalign <= 1'b0;
      if (state_q == IDLE) idle_wait_q <= 1'b0;
      if (state_q == FETCH && imem_ready) begin
        ir_out   <= imem_rdata;
        ir_valid <= 1'b1;
        pc_out   <= pc_q;
      end
      if (state_q == RESOLVE && !stall) begin
        pc_q     <= npc;
        ir_valid <= 1'b0;
        // Pulse depends on the resolved address, so a branch that lands on p4 is silent.
        taken    <= (npc != p4) || trap;
        misalign <= trap;
        if (branch == 4'b1011) link_addr <= p4;
      end
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] ir_out;
  logic        ir_valid;
  logic [31:0] pc_out;
  logic [3:0]  branch;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        stall;
  logic        taken;
  logic [31:0] link_addr;
  logic        misalign;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pc_fetch_unit dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .ir_out(ir_out), .ir_valid(ir_valid), .pc_out(pc_out),
    .branch(branch), .rs_val(rs_val), .rt_val(rt_val),
    .stall(stall), .taken(taken), .link_addr(link_addr), .misalign(misalign)
  );

  // Entered at a negedge in FETCH; returns at the negedge in RESOLVE.
  task automatic fetch_word(input logic [31:0] w);
    imem_ready = 1'b1;
    imem_rdata = w;
    @(negedge clk);
    imem_ready = 1'b0;
    @(negedge clk);
  endtask

  // Entered in RESOLVE; returns at the negedge of the following FETCH cycle.
  task automatic resolve(input logic [3:0] br, input logic [31:0] rs, input logic [31:0] rt);
    branch = br;
    rs_val = rs;
    rt_val = rt;
    @(negedge clk);
    branch = 4'b0000;
  endtask

  // Redirect the PC to an aligned address with a jr.
  task automatic steer(input logic [31:0] target);
    fetch_word(32'h0);
    resolve(4'b0010, target, 32'h0);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({imem_req, ir_valid, taken, misalign} !== 4'b0 || ir_out !== 32'h0 ||
          pc_out !== 32'h0 || link_addr !== 32'h0 || imem_addr !== 32'h0) begin
        failures++;
        $display("FAIL reset_outputs cyc=%0d req=%b valid=%b ir=%h pc_out=%h link=%h addr=%h exp all 0",
                 i, imem_req, ir_valid, ir_out, pc_out, link_addr, imem_addr);
      end
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (imem_req !== 1'b0) begin
      failures++;
      $display("FAIL reset_req_early got=%b exp=0", imem_req);
    end
    @(negedge clk);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      failures++;
      $display("FAIL reset_first_fetch req=%b addr=%h exp req=1 addr=00000000", imem_req, imem_addr);
    end
  endtask

  task automatic test_mem_wait;
    imem_ready = 1'b0;
    imem_rdata = 32'hAAAA_5555;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h0 || ir_valid !== 1'b0 || ir_out !== 32'h0) begin
        failures++;
        $display("FAIL mem_wait_hold cyc=%0d req=%b addr=%h valid=%b ir=%h exp req=1 addr=0 valid=0 ir=0",
                 i, imem_req, imem_addr, ir_valid, ir_out);
      end
    end
    fetch_word(32'hAAAA_5555);
    checks++;
    if (ir_out !== 32'hAAAA_5555 || ir_valid !== 1'b1 || pc_out !== 32'h0 || imem_req !== 1'b0) begin
      failures++;
      $display("FAIL mem_wait_load ir=%h valid=%b pc_out=%h req=%b exp ir=aaaa5555 valid=1 pc_out=0 req=0",
               ir_out, ir_valid, pc_out, imem_req);
    end
    resolve(4'b0000, 32'h0, 32'h0);
    checks++;
    if (imem_addr !== 32'h4 || taken !== 1'b0 || ir_valid !== 1'b0) begin
      failures++;
      $display("FAIL seq_pc4 addr=%h taken=%b valid=%b exp addr=00000004 taken=0 valid=0",
               imem_addr, taken, ir_valid);
    end
  endtask

  task automatic test_beq;
    steer(32'h40);
    checks++;
    if (imem_addr !== 32'h40 || taken !== 1'b1) begin
      failures++;
      $display("FAIL jr_steer addr=%h taken=%b exp addr=00000040 taken=1", imem_addr, taken);
    end
    fetch_word(32'h1000_FFFE);
    resolve(4'b0011, 32'd5, 32'd5);
    checks++;
    if (imem_addr !== 32'h3C || taken !== 1'b1) begin
      failures++;
      $display("FAIL beq_taken addr=%h taken=%b exp addr=0000003c taken=1", imem_addr, taken);
    end
    @(negedge clk);
    checks++;
    if (taken !== 1'b0) begin
      failures++;
      $display("FAIL taken_pulse_width got=%b exp=0", taken);
    end
    imem_ready = 1'b1;
    imem_rdata = 32'h0;
    @(negedge clk);
    imem_ready = 1'b0;
    @(negedge clk);
    resolve(4'b0010, 32'h40, 32'h0);
    fetch_word(32'h1000_FFFE);
    resolve(4'b0011, 32'd5, 32'd6);
    checks++;
    if (imem_addr !== 32'h44 || taken !== 1'b0) begin
      failures++;
      $display("FAIL beq_not_taken addr=%h taken=%b exp addr=00000044 taken=0", imem_addr, taken);
    end
  endtask

  task automatic test_signed;
    fetch_word(32'h0000_0004);
    resolve(4'b0111, 32'hFFFF_FFFF, 32'd1);
    checks++;
    if (imem_addr !== 32'h58 || taken !== 1'b1) begin
      failures++;
      $display("FAIL blt_signed addr=%h taken=%b exp addr=00000058 taken=1", imem_addr, taken);
    end
    fetch_word(32'h0000_0004);
    resolve(4'b1000, 32'hFFFF_FFFF, 32'd1);
    checks++;
    if (imem_addr !== 32'h5C || taken !== 1'b0) begin
      failures++;
      $display("FAIL bgt_signed addr=%h taken=%b exp addr=0000005c taken=0", imem_addr, taken);
    end
  endtask

  task automatic test_jal;
    steer(32'h1000_0010);
    fetch_word({6'h03, 26'h000_0100});
    resolve(4'b1011, 32'h0, 32'h0);
    checks++;
    if (imem_addr !== 32'h1000_0400 || link_addr !== 32'h1000_0014 || taken !== 1'b1) begin
      failures++;
      $display("FAIL jal addr=%h link=%h taken=%b exp addr=10000400 link=10000014 taken=1",
               imem_addr, link_addr, taken);
    end
  endtask

  task automatic test_jr;
    logic [31:0] exp_pc;
    logic        exp_mis;
`ifdef MISALIGN_TRAP_EN
    exp_pc  = 32'h80;
    exp_mis = 1'b1;
`else
    exp_pc  = 32'h200;
    exp_mis = 1'b0;
`endif
    fetch_word(32'h0);
    resolve(4'b0010, 32'h203, 32'h0);
    checks++;
    if (imem_addr !== exp_pc || misalign !== exp_mis || taken !== 1'b1) begin
      failures++;
      $display("FAIL jr_misaligned addr=%h mis=%b taken=%b exp addr=%h mis=%b taken=1",
               imem_addr, misalign, taken, exp_pc, exp_mis);
    end
  endtask

  task automatic test_stall;
    logic [31:0] old_pc;
    old_pc = imem_addr;
    fetch_word(32'h0);
    branch = 4'b0010;
    rs_val = 32'h300;
    stall  = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (imem_addr !== old_pc || imem_req !== 1'b0 || ir_valid !== 1'b1 || taken !== 1'b0) begin
        failures++;
        $display("FAIL stall_hold cyc=%0d addr=%h req=%b valid=%b taken=%b exp addr=%h req=0 valid=1 taken=0",
                 i, imem_addr, imem_req, ir_valid, taken, old_pc);
      end
    end
    stall = 1'b0;
    resolve(4'b0010, 32'h300, 32'h0);
    checks++;
    if (imem_addr !== 32'h300 || taken !== 1'b1 || imem_req !== 1'b1) begin
      failures++;
      $display("FAIL stall_release addr=%h taken=%b req=%b exp addr=00000300 taken=1 req=1",
               imem_addr, taken, imem_req);
    end
  endtask

  task automatic test_rst_mid_fetch;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (imem_req !== 1'b0 || imem_addr !== 32'h0 || ir_valid !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_fetch req=%b addr=%h valid=%b exp req=0 addr=0 valid=0",
               imem_req, imem_addr, ir_valid);
    end
    rst = 1'b0;
    imem_ready = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    checks++;
    if (imem_req !== 1'b0 || ir_valid !== 1'b0 || ir_out !== 32'h0) begin
      failures++;
      $display("FAIL late_ready_ignored req=%b valid=%b ir=%h exp req=0 valid=0 ir=0",
               imem_req, ir_valid, ir_out);
    end
    imem_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      failures++;
      $display("FAIL refetch_after_rst req=%b addr=%h exp req=1 addr=0", imem_req, imem_addr);
    end
  endtask

  task automatic test_back_to_back;
    for (int i = 1; i <= 2; i++) begin
      fetch_word(32'h0000_1234);
      checks++;
      if (pc_out !== 32'(4 * (i - 1))) begin
        failures++;
        $display("FAIL b2b_pc_out n=%0d got=%h exp=%h", i, pc_out, 32'(4 * (i - 1)));
      end
      resolve(4'b1100, 32'h0, 32'h0);
      checks++;
      if (imem_addr !== 32'(4 * i) || taken !== 1'b0) begin
        failures++;
        $display("FAIL b2b_seq n=%0d addr=%h taken=%b exp addr=%h taken=0", i, imem_addr, taken, 32'(4 * i));
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    imem_ready = 1'b0;
    imem_rdata = 32'h0;
    branch     = 4'b0000;
    rs_val     = 32'h0;
    rt_val     = 32'h0;
    stall      = 1'b0;
    test_reset();
    test_mem_wait();
    test_beq();
    test_signed();
    test_jal();
    test_jr();
    test_stall();
    test_rst_mid_fetch();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
